down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
- Loadable down-counter timer for the counter/timer library.
- Counts down from a programmed value on qualified clock enables, and signals terminal count.
- Supports one-shot mode, which halts at zero, and periodic mode, which auto-reloads.
- Used as the countdown companion to the free-running up counters for timeouts, delays and periodic tick generation.

Parameters:
- WIDTH, 3, width of counter, load value and reload register.

Ports:
- clk  input  1  clock; all state changes on rising edge except reset.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  count enable; one decrement per cycle with en=1 while running.
- load  input  1  load strobe; captures load_val into reload register and counter.
- load_val  input  WIDTH  value to load; 0 is legal but blocks start.
- start  input  1  start/resume/restart request.
- stop  input  1  pause request.
- periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot; sampled at each terminal count.
- q  output  WIDTH  current count (registered).
- busy  output  1  1 while in RUN (decoded from state register).
- tc  output  1  terminal-count pulse, registered, exactly one cycle wide.
- done  output  1  one-shot completion flag, registered, held until load/start/reset.

Behaviour:
- Reset (rst=0, async, immediate, also mid-count):
  - q=0, reload register=0, state=IDLE, busy=0, tc=0, done=0.
  - Normal operation resumes on the first clk edge with rst=1.
- States:
  - IDLE: stopped or paused.
  - RUN: counting.
  - DONE: one-shot expired.
- tc defaults to 0 every cycle unless set by a terminal-count event below.
- Priority per edge: load > stop > start > count.
- load (any state):
  - reload register <= load_val; q <= load_val.
  - state <= IDLE; done <= 0; tc <= 0.
  - start/stop/en ignored that cycle.
- stop (no load):
  - RUN -> IDLE, q holds (pause).
  - In IDLE/DONE: no effect.
  - stop and start in the same cycle: stop wins.
- start (no load, no stop):
  - IDLE and q!=0: -> RUN. q unchanged that edge; first decrement on the next edge with en=1.
  - IDLE and q==0: ignored.
  - DONE: q <= reload register, done <= 0. -> RUN if reload register != 0, else -> IDLE.
  - RUN: no effect.
- RUN, en=1, q>1: q <= q-1.
- RUN, en=1, q==1 (terminal count):
  - tc <= 1 for one cycle.
  - periodic=1: q <= reload register, stay RUN. Period = reload value en-cycles; 0 is never presented on q.
  - periodic=0: q <= 0, done <= 1, -> DONE.
- RUN, en=0: q holds; no tc.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - q never decrements below 0; there is no wrap from 0 to all-ones.
  - Max load 2^WIDTH-1 gives 2^WIDTH-1 en-cycles to tc.
- Latency: tc and done are asserted on the same edge that q takes its post-terminal value.
- Changing periodic mid-run: takes effect at the next terminal count only.
- Reset asserted mid-RUN: counter returns to IDLE with q=0; no tc is emitted.

Test Plan:
- Reset: rst=0 with random inputs -> q=000, busy=0, tc=0, done=0 immediately, without a clk edge. Release; idle clocks -> outputs unchanged.
- One-shot: load 101, start, en=1 continuous -> q sequence 101,100,011,010,001,000 on consecutive edges after start. tc high only with q=000; done=1 and busy=0 thereafter. Start again -> q=101, done=0, counting resumes.
- Periodic: load 011, periodic=1, start, en=1 for 9 edges -> q 011,010,001,011,010,001,011,... and tc pulses every 3rd edge (3 pulses), never q=000.
- Enable gating and pause: load 111, start, en toggling 1/0 -> q decrements only on en=1 edges. Stop at q=100 -> busy=0, q holds 100 with en=1. Start -> resumes 011.
- Priority: in RUN, load=1, load_val=010 with stop=1, start=1 -> q=010, state IDLE. stop+start together in IDLE with q!=0 -> stays IDLE. Start with q=000 after load 000 -> stays IDLE, no tc.
- Reset mid-operation: rst=0 while RUN at q=010 -> immediate q=000, busy=0, no tc; load/start after release behaves normally.

Source files
------------

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for the loadable down-counter timer.
// The master side drives commands; the slave side (the timer) returns the count and flags.
interface down_counter_timer_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output en, load, load_val, start, stop, periodic,
    input  q, busy, tc, done
  );

  modport slave (
    input  en, load, load_val, start, stop, periodic,
    output q, busy, tc, done
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot and periodic auto-reload modes.
// Per-edge priority: load > stop > start > count.
//
//   state  | meaning
//   S_IDLE | stopped or paused, count held
//   S_RUN  | counting down on en
//   S_DONE | one-shot expired, q parked at zero
module down_counter_timer #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             done_q;
  logic [WIDTH-1:0] cnt_dec_d;

  assign cnt_dec_d = cnt_q - ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load) begin
        reload_q <= bus.load_val;
        cnt_q    <= bus.load_val;
        state_q  <= S_IDLE;
        done_q   <= 1'b0;
      end else if (bus.stop) begin
        if (state_q == S_RUN) state_q <= S_IDLE;
      end else if (bus.start && state_q != S_RUN) begin
        if (state_q == S_DONE) begin
          // Restart from the reload value; a zero reload cannot run.
          cnt_q   <= reload_q;
          done_q  <= 1'b0;
          state_q <= (reload_q != ZERO) ? S_RUN : S_IDLE;
        end else if (cnt_q != ZERO) begin
          state_q <= S_RUN;
        end
      end else if (state_q == S_RUN && bus.en) begin
        if (cnt_q == ONE) begin
          tc_q <= 1'b1;
          if (bus.periodic) begin
            cnt_q <= reload_q;
          end else begin
            cnt_q   <= ZERO;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end else if (cnt_q != ZERO) begin
          cnt_q <= cnt_dec_d;
        end
      end
    end
  end

  assign bus.q    = cnt_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.tc   = tc_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: reset, one-shot, periodic, gating, priority, mid-run reset.
module tb_down_counter_timer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   tc_cnt;

  down_counter_timer_if #(.WIDTH(3)) bus();

  down_counter_timer #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 3'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.periodic = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int q, input int busy, input int tc, input int done);
    chk({tag, ".q"},    32'(bus.q),    q);
    chk({tag, ".busy"}, 32'(bus.busy), busy);
    chk({tag, ".tc"},   32'(bus.tc),   tc);
    chk({tag, ".done"}, 32'(bus.done), done);
  endtask

  task automatic do_load(input int v);
    idle_inputs();
    bus.load     = 1'b1;
    bus.load_val = 3'(v);
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.en       = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 3'($urandom_range(7, 0));
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.periodic = 1'($urandom_range(1, 0));
    #1 rst = 1'b0;
    #1;
    chk_all("reset_async", 0, 0, 0, 0);
    idle_inputs();
    step();
    step();
    chk_all("reset_held", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    chk_all("post_release", 0, 0, 0, 0);

    // One-shot from 5
    do_load(5);
    chk_all("os_load", 5, 0, 0, 0);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    bus.start = 1'b0;
    chk_all("os_start", 5, 1, 0, 0);
    for (int k = 4; k >= 1; k--) begin
      step();
      chk_all("os_count", k, 1, 0, 0);
    end
    step();
    chk_all("os_tc", 0, 0, 1, 1);
    step();
    chk_all("os_after", 0, 0, 0, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_all("os_restart", 5, 1, 0, 0);
    step();
    chk_all("os_resume", 4, 1, 0, 0);

    // Periodic reload of 3
    do_load(3);
    bus.periodic = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    chk_all("per_start", 3, 1, 0, 0);
    bus.en = 1'b1;
    tc_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      case (i % 3)
        0: chk_all("per_seq", 2, 1, 0, 0);
        1: chk_all("per_seq", 1, 1, 0, 0);
        default: chk_all("per_seq", 3, 1, 1, 0);
      endcase
      if (bus.tc) tc_cnt++;
    end
    chk("per_tc_count", tc_cnt, 3);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("per_stop", 3, 0, 0, 0);

    // Enable gating and pause from 7
    do_load(7);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_all("gate_start", 7, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      bus.en = (i % 2 == 0);
      step();
      chk_all("gate_seq", 6 - i / 2, 1, 0, 0);
    end
    bus.en   = 1'b1;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_all("pause", 4, 0, 0, 0);
    step();
    chk_all("pause_hold", 4, 0, 0, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_all("resume_start", 4, 1, 0, 0);
    step();
    chk_all("resume_count", 3, 1, 0, 0);

    // Priority: load beats stop/start/en
    bus.load     = 1'b1;
    bus.load_val = 3'd2;
    bus.stop     = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.load = 1'b0;
    chk_all("prio_load", 2, 0, 0, 0);
    step();
    chk_all("prio_stop_start", 2, 0, 0, 0);
    do_load(0);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    step();
    chk_all("start_zero", 0, 0, 0, 0);
    step();
    chk_all("start_zero_hold", 0, 0, 0, 0);
    idle_inputs();

    // Reset while running at q=2
    do_load(3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.en    = 1'b1;
    step();
    chk_all("mid_pre", 2, 1, 0, 0);
    rst = 1'b0;
    #1;
    chk_all("mid_reset", 0, 0, 0, 0);
    step();
    chk_all("mid_reset_held", 0, 0, 0, 0);
    rst = 1'b1;
    idle_inputs();
    step();
    chk_all("mid_release", 0, 0, 0, 0);
    do_load(2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.en    = 1'b1;
    step();
    chk_all("mid_after1", 1, 1, 0, 0);
    step();
    chk_all("mid_after_tc", 0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
